// File: rtl/tb_run_controller_if.sv
// Control/result bundle between a run requester and the run controller.
// The controller takes the slave side; the requester or bench takes the master side.
interface tb_run_controller_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_start;
  logic             i_abort;
  logic [WIDTH-1:0] i_run_len;
  logic [WIDTH-1:0] i_drain_len;
  logic [WIDTH-1:0] i_data_ctr;
  logic [WIDTH-1:0] i_event_ctr;
  logic             o_tb_reset;
  logic             o_enable;
  logic             o_freeze;
  logic             o_busy;
  logic             o_done;
  logic             o_pass;
  logic             o_aborted;
  logic [WIDTH-1:0] o_res_data;
  logic [WIDTH-1:0] o_res_events;

  modport master (
    output i_start, i_abort, i_run_len, i_drain_len, i_data_ctr, i_event_ctr,
    input  o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_pass, o_aborted,
           o_res_data, o_res_events
  );

  modport slave (
    input  i_start, i_abort, i_run_len, i_drain_len, i_data_ctr, i_event_ctr,
    output o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_pass, o_aborted,
           o_res_data, o_res_events
  );
endinterface

// File: rtl/tb_run_controller.sv
// Sequences one test run: clear, stimulus, drain, freeze, capture of the
// scoreboard counters and pass/fail reporting. All outputs are registered.
module tb_run_controller #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CLEAR_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  tb_run_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    FREEZE  = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] run_len_q, run_len_d;
  logic [WIDTH-1:0] drain_len_q, drain_len_d;
  logic             abort_q, abort_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [WIDTH-1:0] res_events_q, res_events_d;
  logic             pass_q, pass_d;
  logic             aborted_q, aborted_d;
  logic             tb_reset_q, tb_reset_d;
  logic             enable_q, enable_d;
  logic             freeze_q, freeze_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state, counters and result capture; outputs follow the next state so they register cleanly
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_len_d    = run_len_q;
    drain_len_d  = drain_len_q;
    abort_d      = abort_q;
    res_data_d   = res_data_q;
    res_events_d = res_events_q;
    pass_d       = pass_q;
    aborted_d    = aborted_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_d     = CLEAR;
          cnt_d       = WIDTH'(1);
          run_len_d   = bus.i_run_len;
          drain_len_d = bus.i_drain_len;
          abort_d     = 1'b0;
          pass_d      = 1'b0;
          aborted_d   = 1'b0;
        end
      end
      CLEAR: begin
        if (bus.i_abort) begin
          abort_d = 1'b1;
          state_d = FREEZE;
        end else if (cnt_q == WIDTH'(CLEAR_CYCLES)) begin
          cnt_d = WIDTH'(1);
          if (run_len_q != '0)        state_d = RUN;
          else if (drain_len_q != '0) state_d = DRAIN;
          else                        state_d = FREEZE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      RUN: begin
        // counter stops at the terminal value, so an all-ones length never wraps
        if (bus.i_abort) begin
          abort_d = 1'b1;
          state_d = FREEZE;
        end else if (cnt_q == run_len_q) begin
          cnt_d   = WIDTH'(1);
          state_d = (drain_len_q != '0) ? DRAIN : FREEZE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      DRAIN: begin
        if (bus.i_abort) begin
          abort_d = 1'b1;
          state_d = FREEZE;
        end else if (cnt_q == drain_len_q) begin
          state_d = FREEZE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      FREEZE: begin
        abort_d = abort_q | bus.i_abort;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        abort_d      = abort_q | bus.i_abort;
        res_data_d   = bus.i_data_ctr;
        res_events_d = bus.i_event_ctr;
        aborted_d    = abort_q | bus.i_abort;
        pass_d       = (bus.i_event_ctr == '0) && !(abort_q | bus.i_abort);
        state_d      = DONE;
      end
      default: state_d = IDLE;
    endcase

    tb_reset_d = (state_d == CLEAR);
    enable_d   = (state_d == RUN);
    freeze_d   = (state_d == FREEZE) || (state_d == CAPTURE) || (state_d == DONE);
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_len_q    <= '0;
      drain_len_q  <= '0;
      abort_q      <= 1'b0;
      res_data_q   <= '0;
      res_events_q <= '0;
      pass_q       <= 1'b0;
      aborted_q    <= 1'b0;
      tb_reset_q   <= 1'b0;
      enable_q     <= 1'b0;
      freeze_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_len_q    <= run_len_d;
      drain_len_q  <= drain_len_d;
      abort_q      <= abort_d;
      res_data_q   <= res_data_d;
      res_events_q <= res_events_d;
      pass_q       <= pass_d;
      aborted_q    <= aborted_d;
      tb_reset_q   <= tb_reset_d;
      enable_q     <= enable_d;
      freeze_q     <= freeze_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_tb_reset   = tb_reset_q;
  assign bus.o_enable     = enable_q;
  assign bus.o_freeze     = freeze_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_pass       = pass_q;
  assign bus.o_aborted    = aborted_q;
  assign bus.o_res_data   = res_data_q;
  assign bus.o_res_events = res_events_q;

endmodule

// File: tb/tb_tb_run_controller.sv
// Randomised bench for tb_run_controller: each run's expected timeline and
// results are computed arithmetically from the programmed lengths and abort point.
module tb_tb_run_controller;

  localparam int unsigned WIDTH = 32;
  localparam longint      CC    = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   inject_en = 1'b0;
  logic [63:0] prev_data = '0;
  logic [63:0] prev_ev = '0;
  logic [WIDTH-1:0] data_q = '0;
  logic [WIDTH-1:0] ev_q = '0;

  tb_run_controller_if #(.WIDTH(WIDTH)) bus ();

  tb_run_controller #(.WIDTH(WIDTH), .CLEAR_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stand-in scoreboard: counts enabled cycles, optional mismatch on the first one
  always_ff @(posedge clk) begin
    if (bus.o_tb_reset) begin
      data_q <= '0;
      ev_q   <= '0;
    end else if (bus.o_enable) begin
      data_q <= data_q + 32'd1;
      if (inject_en && data_q == '0) ev_q <= ev_q + 32'd1;
    end
  end
  assign bus.i_data_ctr  = data_q;
  assign bus.i_event_ctr = ev_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_tb_reset"}, 64'(bus.o_tb_reset), 64'd0);
    check({pfx, "_enable"},   64'(bus.o_enable),   64'd0);
    check({pfx, "_freeze"},   64'(bus.o_freeze),   64'd0);
    check({pfx, "_busy"},     64'(bus.o_busy),     64'd0);
    check({pfx, "_done"},     64'(bus.o_done),     64'd0);
    check({pfx, "_pass"},     64'(bus.o_pass),     64'd0);
    check({pfx, "_aborted"},  64'(bus.o_aborted),  64'd0);
    check({pfx, "_res_data"}, 64'(bus.o_res_data), 64'd0);
    check({pfx, "_res_ev"},   64'(bus.o_res_events), 64'd0);
  endtask

  // abort_at: edge index (0 = start edge) at which i_abort is sampled; -1 = none
  task automatic run_one(input logic [31:0] rl, input logic [31:0] dl,
                         input longint abort_at, input bit inject);
    longint n, t, en_end, en_cycles, exp_ev;
    bit ab;
    n  = CC + longint'(rl) + longint'(dl);
    t  = (abort_at >= 1 && abort_at <= n) ? abort_at : n;
    en_end    = (CC + longint'(rl) < t) ? CC + longint'(rl) : t;
    en_cycles = (en_end > CC) ? en_end - CC : 0;
    exp_ev    = (inject && en_cycles > 0) ? 1 : 0;
    ab        = (abort_at >= 1) && (abort_at <= t + 2);
    inject_en = inject;

    bus.i_start     = 1'b1;
    bus.i_run_len   = rl;
    bus.i_drain_len = dl;
    bus.i_abort     = (abort_at == 0);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;

    for (longint k = 0; k <= t + 4; k++) begin
      check("busy",     64'(bus.o_busy),     64'(k < t + 2));
      check("tb_reset", 64'(bus.o_tb_reset), 64'(k < ((CC < t) ? CC : t)));
      check("enable",   64'(bus.o_enable),   64'(k >= CC && k < en_end));
      check("freeze",   64'(bus.o_freeze),   64'(k >= t));
      check("done",     64'(bus.o_done),     64'(k >= t + 2));
      if (k >= t + 2) begin
        check("pass",     64'(bus.o_pass),       64'(exp_ev == 0 && !ab));
        check("aborted",  64'(bus.o_aborted),    64'(ab));
        check("res_data", 64'(bus.o_res_data),   64'(en_cycles));
        check("res_ev",   64'(bus.o_res_events), 64'(exp_ev));
      end else begin
        check("pass_cleared",    64'(bus.o_pass),       64'd0);
        check("aborted_cleared", 64'(bus.o_aborted),    64'd0);
        check("res_data_held",   64'(bus.o_res_data),   prev_data);
        check("res_ev_held",     64'(bus.o_res_events), prev_ev);
      end
      // stray starts while busy and stray aborts once done must both be ignored
      bus.i_abort     = (k == abort_at - 1) || (k >= t + 2 && $urandom_range(0, 3) == 0);
      bus.i_start     = (k <= t + 1) && ($urandom_range(0, 4) == 0);
      bus.i_run_len   = $urandom;
      bus.i_drain_len = $urandom;
      @(posedge clk); #1;
    end
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    prev_data   = 64'(en_cycles);
    prev_ev     = 64'(exp_ev);
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_run_len   = '0;
    bus.i_drain_len = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    check_quiet("idle");

    run_one(32'd10, 32'd3, -1, 1'b0);
    run_one(32'd10, 32'd3, -1, 1'b1);
    run_one(32'd0,  32'd0, -1, 1'b0);
    run_one(32'd50, 32'd2, 9,  1'b0);
    run_one(32'd3,  32'd1, 0,  1'b0);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, 1'b1);
    run_one(32'd0,  32'd5, 3,  1'b0);
    run_one(32'd4,  32'd0, 10, 1'b0);

    for (int r = 0; r < 14; r++) begin
      logic [31:0] rl, dl;
      longint ab_at;
      rl = 32'($urandom_range(0, 20));
      dl = 32'($urandom_range(0, 6));
      ab_at = ($urandom_range(0, 2) == 0) ?
              longint'($urandom_range(1, 32'(CC) + rl + dl + 3)) : -1;
      run_one(rl, dl, ab_at, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a long run
    bus.i_start     = 1'b1;
    bus.i_run_len   = 32'd100;
    bus.i_drain_len = 32'd0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_quiet("async_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_quiet("post_rst");
    end
    prev_data = '0;
    prev_ev   = '0;
    run_one(32'd6, 32'd2, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
